// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_div_pkg;

  localparam int W_DEF  = 8;
  localparam int DW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_if.sv
// Operand/result handshake bundle between a requester and seq_div.
interface seq_div_if
  import seq_div_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int DW = DW_DEF
);

  logic          start;
  logic [W-1:0]  a;
  logic [DW-1:0] b;
  logic [W-1:0]  q;
  logic [DW-1:0] r;
  logic          busy;
  logic          done;
  logic          div0;

  modport master (
    output start, a, b,
    input  q, r, busy, done, div0
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, div0
  );

endinterface

// File: rtl/seq_div_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits.
module div_step #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] p_in,
  input  logic          bit_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] p_out,
  output logic          q_bit
);

  logic [DW:0] t;

  // Trial remainder carries one extra bit so the compare cannot wrap; after a
  // successful subtract the result always fits back into DW bits.
  always_comb begin
    t     = {p_in, bit_in};
    q_bit = (t >= {1'b0, b_in});
    p_out = q_bit ? (t[DW-1:0] - b_in) : t[DW-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, start/done
// handshake, divide-by-zero flagged with a saturated quotient.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; operands captured on the accepting edge
// ST_BUSY | one restoring step per edge, W edges in total
// ST_DONE | done pulse for one cycle, then back to idle
module seq_div
  import seq_div_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int DW = DW_DEF
) (
  input  logic     clk,
  input  logic     reset,
  seq_div_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  a_shift;
  logic [DW-1:0] b_reg;
  logic [DW-1:0] p_reg;
  logic [DW-1:0] p_nxt;
  logic          q_bit;
  logic [CW-1:0] cnt;
  logic          b_zero;
  logic          last_step;

  div_step #(.DW(DW)) u_step (
    .p_in   (p_reg),
    .bit_in (a_reg[W-1]),
    .b_in   (b_reg),
    .p_out  (p_nxt),
    .q_bit  (q_bit)
  );

  assign a_shift   = {a_reg[W-2:0], q_bit};
  assign b_zero    = (bus.b == '0);
  assign last_step = (cnt == CW'(1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = b_zero ? ST_DONE : ST_BUSY;
      ST_BUSY: if (last_step) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs follow the state directly.
  always_comb begin
    bus.busy = (state == ST_BUSY);
    bus.done = (state == ST_DONE);
  end

  // Operand capture, iteration and result registers; results are only
  // overwritten at completion so they stay valid through the next run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      p_reg    <= '0;
      cnt      <= '0;
      bus.q    <= '0;
      bus.r    <= '0;
      bus.div0 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (!b_zero) begin
              a_reg    <= bus.a;
              b_reg    <= bus.b;
              p_reg    <= '0;
              cnt      <= CW'(W);
              bus.div0 <= 1'b0;
            end else begin
              bus.q    <= '1;
              bus.r    <= '0;
              bus.div0 <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          a_reg <= a_shift;
          p_reg <= p_nxt;
          cnt   <= cnt - CW'(1);
          if (last_step) begin
            bus.q <= a_shift;
            bus.r <= p_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
